lcd_cmd_sequencer: RTL and testbench

LCD_CMD_SEQUENCER -- requirements
Module: lcd_cmd_sequencer

---
 rtl/lcd_pkg.sv | 37 +++
 rtl/lcd_cmd_sequencer_if.sv | 23 ++
 rtl/lcd_delay_counter.sv | 22 ++
 rtl/lcd_cmd_sequencer.sv | 148 ++++++++++++++
 tb/tb_lcd_cmd_sequencer.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: state encoding, command bit layout, timing defaults and the power-on init table
// shared by the LCD command sequencer files.
package lcd_pkg;

    localparam int CNT_W      = 20;
    localparam int CMD_RS     = 9;
    localparam int CMD_RW     = 8;
    localparam int CMD_SF_MSB = 7;

    localparam int DEF_SETUP     = 2;
    localparam int DEF_PULSE     = 12;
    localparam int DEF_HOLD      = 1;
    localparam int DEF_WAIT_S    = 2000;
    localparam int DEF_WAIT_L    = 82000;
    localparam int DEF_INIT_WAIT = 750000;

    typedef enum logic [2:0] {
        ST_INIT_DLY,
        ST_INIT_CMD,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
    } state_e;

    // Function set 8-bit/2-line, display on, entry mode increment, clear.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        return idx == 2'd0 ? 8'h38 : idx == 2'd1 ? 8'h0C : idx == 2'd2 ? 8'h06 : 8'h01;
    endfunction

    // Clear (0x01) and home (0x02/0x03) need the long execution wait.
    function automatic logic is_long_wait(input logic rs, input logic [7:0] sf);
        return !rs && sf[7:2] == 6'd0;
    endfunction

endpackage

// File: rtl/lcd_cmd_sequencer_if.sv
// lcd_cmd_sequencer_if: command-buffer handshake plus LCD pin bundle; master is the sequencer.
interface lcd_cmd_sequencer_if #(
    parameter int DATA_WIDTH = 10
);
    logic [DATA_WIDTH-1:0] cmd_data;
    logic                  cmd_valid;
    logic                  cmd_pop;
    logic                  lcd_rs;
    logic                  lcd_rw;
    logic                  lcd_e;
    logic [7:0]            sf_d;
    logic                  busy;

    modport master (
        input  cmd_data, cmd_valid,
        output cmd_pop, lcd_rs, lcd_rw, lcd_e, sf_d, busy
    );

    modport slave (
        output cmd_data, cmd_valid,
        input  cmd_pop, lcd_rs, lcd_rw, lcd_e, sf_d, busy
    );
endinterface

// File: rtl/lcd_delay_counter.sv
// lcd_delay_counter: loadable 20-bit down-counter; done_o flags the last cycle of a loaded duration.
module lcd_delay_counter
    import lcd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load_i ? value_i : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);

    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;

    assign done_o = cnt_q == CNT_W'(1);

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer: pops LCD commands and plays them out with setup/E-pulse/hold/execution timing.
// Define LCD_INIT_EN to add the power-on delay and the built-in init command sequence.
module lcd_cmd_sequencer
    import lcd_pkg::*;
#(
    parameter int DATA_WIDTH   = 10,
    parameter int SETUP_CYCLES = DEF_SETUP,
    parameter int PULSE_CYCLES = DEF_PULSE,
    parameter int HOLD_CYCLES  = DEF_HOLD,
    parameter int WAIT_SHORT   = DEF_WAIT_S,
    parameter int WAIT_LONG    = DEF_WAIT_L,
    parameter int INIT_WAIT    = DEF_INIT_WAIT
) (
    input logic                 clk,
    input logic                 reset,
    lcd_cmd_sequencer_if.master bus
);

    localparam longint MAX_CYC = 64'd1 << CNT_W;

    if (DATA_WIDTH < 10 ||
        SETUP_CYCLES < 1 || SETUP_CYCLES >= MAX_CYC ||
        PULSE_CYCLES < 1 || PULSE_CYCLES >= MAX_CYC ||
        HOLD_CYCLES  < 1 || HOLD_CYCLES  >= MAX_CYC ||
        WAIT_SHORT   < 1 || WAIT_SHORT   >= MAX_CYC ||
        WAIT_LONG    < 1 || WAIT_LONG    >= MAX_CYC ||
        INIT_WAIT    < 1 || INIT_WAIT    >= MAX_CYC) begin : g_bad_param
        $error("lcd_cmd_sequencer: cycle parameters must lie in [1, 2^20)");
    end

`ifdef LCD_INIT_EN
    localparam state_e RESET_STATE = ST_INIT_DLY;
`else
    localparam state_e RESET_STATE = ST_IDLE;
`endif

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] cmd_q, cmd_d;
    logic                  load;
    logic [CNT_W-1:0]      load_val;
    logic                  done;
    state_e                wait_exit;

    lcd_delay_counter u_cnt (
        .clk    (clk),
        .reset  (reset),
        .load_i (load),
        .value_i(load_val),
        .done_o (done)
    );

`ifdef LCD_INIT_EN
    logic       init_q;
    logic       armed_q;
    logic [1:0] idx_q;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            init_q  <= 1'b1;
            armed_q <= 1'b0;
            idx_q   <= 2'd0;
        end else begin
            if (state_q == ST_INIT_DLY) armed_q <= 1'b1;
            if (state_q == ST_WAIT && done && init_q) begin
                idx_q  <= idx_q + 2'd1;
                init_q <= idx_q != 2'd3;
            end
        end

    assign wait_exit = init_q && idx_q != 2'd3 ? ST_INIT_CMD : ST_IDLE;
`else
    assign wait_exit = ST_IDLE;
`endif

    always_ff @(posedge clk or negedge reset)
        if (!reset) state_q <= RESET_STATE;
        else        state_q <= state_d;

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_val = '0;
        unique case (state_q)
`ifdef LCD_INIT_EN
            ST_INIT_DLY:
                if (!armed_q) begin
                    load     = 1'b1;
                    load_val = CNT_W'(INIT_WAIT);
                end else if (done) state_d = ST_INIT_CMD;
            ST_INIT_CMD: begin
                state_d  = ST_SETUP;
                load     = 1'b1;
                load_val = CNT_W'(SETUP_CYCLES);
            end
`endif
            ST_IDLE:
                if (bus.cmd_valid) begin
                    state_d  = ST_SETUP;
                    load     = 1'b1;
                    load_val = CNT_W'(SETUP_CYCLES);
                end
            ST_SETUP:
                if (done) begin
                    state_d  = ST_PULSE;
                    load     = 1'b1;
                    load_val = CNT_W'(PULSE_CYCLES);
                end
            ST_PULSE:
                if (done) begin
                    state_d  = ST_HOLD;
                    load     = 1'b1;
                    load_val = CNT_W'(HOLD_CYCLES);
                end
            ST_HOLD:
                if (done) begin
                    state_d  = ST_WAIT;
                    load     = 1'b1;
                    load_val = is_long_wait(cmd_q[CMD_RS], cmd_q[CMD_SF_MSB:0]) ?
                               CNT_W'(WAIT_LONG) : CNT_W'(WAIT_SHORT);
                end
            ST_WAIT:
                if (done) state_d = wait_exit;
            default: state_d = RESET_STATE;
        endcase
    end

    always_comb begin
        cmd_d = bus.cmd_pop ? bus.cmd_data : cmd_q;
`ifdef LCD_INIT_EN
        if (state_q == ST_INIT_CMD) cmd_d = DATA_WIDTH'(init_cmd(idx_q));
`endif
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) cmd_q <= '0;
        else        cmd_q <= cmd_d;

    // cmd_pop is gated by reset so a pending command is never acknowledged mid-reset.
    always_comb begin
        bus.cmd_pop = state_q == ST_IDLE && bus.cmd_valid && reset;
        bus.lcd_e   = state_q == ST_PULSE;
        bus.busy    = state_q != ST_IDLE;
        bus.lcd_rs  = cmd_q[CMD_RS];
        bus.lcd_rw  = cmd_q[CMD_RW];
        bus.sf_d    = cmd_q[CMD_SF_MSB:0];
    end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// tb_lcd_cmd_sequencer: directed checks of command timing, wait selection, FIFO order and reset abort.
// Build with LCD_INIT_EN defined to check the power-on init sequence instead.
module tb_lcd_cmd_sequencer;

    localparam int DW = 10;
    localparam int TN = 128;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    logic [DW-1:0] fifo[$];
    logic          tr_pop[TN];
    logic          tr_e[TN];
    logic          tr_rs[TN];
    logic          tr_rw[TN];
    logic          tr_busy[TN];
    logic [7:0]    tr_sf[TN];
    logic [7:0]    rise_sf[$];

    lcd_cmd_sequencer_if #(.DATA_WIDTH(DW)) bus ();

    lcd_cmd_sequencer #(
        .DATA_WIDTH  (DW),
        .SETUP_CYCLES(2),
        .PULSE_CYCLES(3),
        .HOLD_CYCLES (1),
        .WAIT_SHORT  (5),
        .WAIT_LONG   (9),
        .INIT_WAIT   (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic feed();
        bus.cmd_valid = fifo.size() != 0;
        bus.cmd_data  = fifo.size() != 0 ? fifo[0] : '0;
    endtask

    task automatic push(input logic [DW-1:0] c);
        fifo.push_back(c);
        feed();
    endtask

    // Trace n cycles sampled on the falling edge; a sampled pop retires the FIFO head after the edge.
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            tr_pop[k]  = bus.cmd_pop;
            tr_e[k]    = bus.lcd_e;
            tr_rs[k]   = bus.lcd_rs;
            tr_rw[k]   = bus.lcd_rw;
            tr_busy[k] = bus.busy;
            tr_sf[k]   = bus.sf_d;
            @(posedge clk);
            #1;
            if (tr_pop[k]) void'(fifo.pop_front());
            feed();
        end
    endtask

    function automatic int cnt_pop(input int n);
        int c = 0;
        for (int k = 0; k < n; k++) c += int'(tr_pop[k]);
        return c;
    endfunction

    function automatic int cnt_e(input int n);
        int c = 0;
        for (int k = 0; k < n; k++) c += int'(tr_e[k]);
        return c;
    endfunction

    function automatic int cnt_busy(input int n);
        int c = 0;
        for (int k = 0; k < n; k++) c += int'(tr_busy[k]);
        return c;
    endfunction

    function automatic int first_e(input int n);
        for (int k = 0; k < n; k++) if (tr_e[k]) return k;
        return -1;
    endfunction

    function automatic int nth_pop(input int n, input int i);
        int c = 0;
        for (int k = 0; k < n; k++) if (tr_pop[k]) begin
            if (c == i) return k;
            c++;
        end
        return -1;
    endfunction

    initial begin
        int p0, p1, p2;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        push(10'h241);
        #12;
        chk("rst_e",    32'(bus.lcd_e),   32'd0);
        chk("rst_rs",   32'(bus.lcd_rs),  32'd0);
        chk("rst_rw",   32'(bus.lcd_rw),  32'd0);
        chk("rst_sf",   32'(bus.sf_d),    32'h00);
        chk("rst_pop",  32'(bus.cmd_pop), 32'd0);
`ifdef LCD_INIT_EN
        chk("rst_busy", 32'(bus.busy),    32'd1);
`else
        chk("rst_busy", 32'(bus.busy),    32'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;
`ifdef LCD_INIT_EN
        run(80);
        p0 = nth_pop(80, 0);
        for (int k = 0; k < 80; k++)
            if (tr_e[k] && (k == 0 || !tr_e[k-1]) && (p0 < 0 || k < p0)) rise_sf.push_back(tr_sf[k]);
        chk("init_busy",     32'(tr_busy[0]), 32'd1);
        chk("init_delay",    32'(first_e(80) >= 12), 32'd1);
        chk("init_rises",    32'(rise_sf.size()), 32'd4);
        chk("init_cmd0",     32'(rise_sf.size() > 0 ? rise_sf[0] : 8'hFF), 32'h38);
        chk("init_cmd1",     32'(rise_sf.size() > 1 ? rise_sf[1] : 8'hFF), 32'h0C);
        chk("init_cmd2",     32'(rise_sf.size() > 2 ? rise_sf[2] : 8'hFF), 32'h06);
        chk("init_cmd3",     32'(rise_sf.size() > 3 ? rise_sf[3] : 8'hFF), 32'h01);
        chk("init_pop_cnt",  32'(cnt_pop(80)), 32'd1);
        chk("init_pop_seen", 32'(p0 > 0), 32'd1);
        chk("init_user_sf",  32'(p0 > 0 ? tr_sf[p0+1] : 8'hFF), 32'h41);
`else
        // Basic command: pop in trace cycle 0, SETUP 1-2, PULSE 3-5, HOLD 6, WAIT 7-11.
        run(14);
        chk("t1_pop_cnt",  32'(cnt_pop(14)), 32'd1);
        chk("t1_pop_idx",  32'(nth_pop(14, 0)), 32'd0);
        chk("t1_sf",       32'(tr_sf[1]), 32'h41);
        chk("t1_rs",       32'(tr_rs[1]), 32'd1);
        chk("t1_rw",       32'(tr_rw[1]), 32'd0);
        chk("t1_e_rise",   32'(first_e(14)), 32'd3);
        chk("t1_e_len",    32'(cnt_e(14)), 32'd3);
        chk("t1_sf_hold",  32'(tr_sf[6]), 32'h41);
        chk("t1_busy_len", 32'(cnt_busy(14)), 32'd11);
        // Busy span = 2 + 3 + 1 + wait: long 15, short 11.
        push(10'h001); run(20);
        chk("t2_clear_sf",   32'(tr_sf[1]), 32'h01);
        chk("t2_clear_busy", 32'(cnt_busy(20)), 32'd15);
        push(10'h006); run(16);
        chk("t2_entry_busy", 32'(cnt_busy(16)), 32'd11);
        push(10'h002); run(20);
        chk("t2_home_busy",  32'(cnt_busy(20)), 32'd15);
        push(10'h004); run(16);
        chk("t2_sf2_busy",   32'(cnt_busy(16)), 32'd11);
        push(10'h201); run(16);
        chk("t2_rs1_busy",   32'(cnt_busy(16)), 32'd11);
        // Back-to-back short commands pop every 12 cycles in FIFO order.
        push(10'h230); push(10'h231); push(10'h232);
        run(40);
        p0 = nth_pop(40, 0);
        p1 = nth_pop(40, 1);
        p2 = nth_pop(40, 2);
        chk("t3_pop_cnt", 32'(cnt_pop(40)), 32'd3);
        chk("t3_pop0",    32'(p0), 32'd0);
        chk("t3_pop1",    32'(p1), 32'd12);
        chk("t3_pop2",    32'(p2), 32'd24);
        chk("t3_sf0",     32'(tr_sf[1]),  32'h30);
        chk("t3_sf1",     32'(tr_sf[13]), 32'h31);
        chk("t3_sf2",     32'(tr_sf[25]), 32'h32);
        // Reset during the second PULSE cycle of 0x250; 0x251 must be next.
        push(10'h250); push(10'h251);
        run(4);
        chk("t4_e_pre",  32'(bus.lcd_e), 32'd1);
        chk("t4_sf_pre", 32'(bus.sf_d),  32'h50);
        reset = 1'b0;
        #1;
        chk("t4_e_rst",    32'(bus.lcd_e),   32'd0);
        chk("t4_sf_rst",   32'(bus.sf_d),    32'h00);
        chk("t4_rs_rst",   32'(bus.lcd_rs),  32'd0);
        chk("t4_pop_rst",  32'(bus.cmd_pop), 32'd0);
        chk("t4_busy_rst", 32'(bus.busy),    32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk("t4_idle", 32'(bus.busy), 32'd0);
        run(14);
        chk("t4_pop_cnt", 32'(cnt_pop(14)), 32'd1);
        chk("t4_pop_idx", 32'(nth_pop(14, 0)), 32'd0);
        chk("t4_next_sf", 32'(tr_sf[1]), 32'h51);
        chk("t4_e_len",   32'(cnt_e(14)), 32'd3);
        // Empty buffer: fully quiet for 100 cycles.
        run(100);
        chk("t5_busy", 32'(cnt_busy(100)), 32'd0);
        chk("t5_pop",  32'(cnt_pop(100)),  32'd0);
        chk("t5_e",    32'(cnt_e(100)),    32'd0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
